mem_copy_engine: RTL

Memory-to-memory block copy initiator that drives the data-memory port (Addr / WD / MemWrite / OpWidth / LoadSigned / RD) as a master. Given a source address, destination address and byte length, it moves the block by alternating one read cycle and one write cycle per transfer. Each transfer uses the widest access (word, half or byte) that the current alignment and remaining length permit. It sits beside the pipeline and owns the DM port while Busy is high; the port mux outside this block is not part of this spec.

---
 rtl/mem_copy_engine.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: block copy master for the data-memory port.
// Moves Len bytes from SrcAddr to DstAddr in ascending order, one read cycle
// followed by one write cycle per transfer, using the widest access that the
// current source/destination alignment and remaining length allow.
module mem_copy_engine #(
  parameter int LEN_W = 12
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [31:0]      SrcAddr,
  input  logic [31:0]      DstAddr,
  input  logic [LEN_W-1:0] Len,
  output logic             Busy,
  output logic             Done,
  output logic [31:0]      Addr,
  output logic [31:0]      WD,
  output logic             MemWrite,
  output logic [1:0]       OpWidth,
  output logic             LoadSigned,
  input  logic [31:0]      RD
);

  localparam logic [1:0] W_WORD = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_BYTE = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, next_state;
  logic [31:0]      src, dst, data_buf;
  logic [LEN_W-1:0] rem, rem_next;
  logic [1:0]       width;
  logic [2:0]       step;

  // Widest access permitted by both addresses and the bytes still to move.
  function automatic logic [1:0] sel_width(input logic [31:0] s,
                                           input logic [31:0] d,
                                           input logic [LEN_W-1:0] r);
    if (s[1:0] == 2'b00 && d[1:0] == 2'b00 && r >= LEN_W'(4))
      return W_WORD;
    else if (!s[0] && !d[0] && r >= LEN_W'(2))
      return W_HALF;
    else
      return W_BYTE;
  endfunction

  // Byte count moved by one transfer of the given width.
  function automatic logic [2:0] width_step(input logic [1:0] w);
    case (w)
      W_WORD:  return 3'd4;
      W_HALF:  return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

  // src/dst/rem are stable from READ into WRITE, so the width computed here
  // is automatically the same for both halves of a transfer.
  assign width    = sel_width(src, dst, rem);
  assign step     = width_step(width);
  assign rem_next = rem - LEN_W'(step);

  // State register; asynchronous reset drops the port strobes immediately.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic and port outputs, decoded from registered state only.
  always_comb begin
    next_state = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    Addr       = 32'd0;
    WD         = 32'd0;
    MemWrite   = 1'b0;
    OpWidth    = W_WORD;
    LoadSigned = 1'b0;
    case (state)
      IDLE: begin
        if (Start) next_state = (Len != '0) ? READ : DONE;
      end
      READ: begin
        Busy       = 1'b1;
        Addr       = src;
        OpWidth    = width;
        next_state = WRITE;
      end
      WRITE: begin
        Busy       = 1'b1;
        Addr       = dst;
        WD         = data_buf;
        OpWidth    = width;
        MemWrite   = 1'b1;
        next_state = (rem_next == '0) ? DONE : READ;
      end
      DONE: begin
        Busy       = 1'b1;
        Done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Copy parameters and the read buffer; Start is only honoured in IDLE.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      src      <= 32'd0;
      dst      <= 32'd0;
      rem      <= '0;
      data_buf <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            src <= SrcAddr;
            dst <= DstAddr;
            rem <= Len;
          end
        end
        READ: data_buf <= RD;
        WRITE: begin
          src <= src + 32'(step);
          dst <= dst + 32'(step);
          rem <= rem_next;
        end
        default: ;
      endcase
    end
  end

endmodule
